// File: rtl/bcd_cnt_pkg.sv
// Shared constants and helpers for the BCD decade counter.
// Provides the digit width, the BCD digit maximum, the binary shadow width,
// a per-digit validity check and a BCD-to-binary conversion used on load.
package bcd_cnt_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int unsigned BIN_W      = 32;
  localparam int unsigned MAX_DIGITS = 8;

  // True when a nibble holds a legal decimal digit.
  function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

  // Converts the low n digits of a packed BCD word to binary.
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BIN_W-1:0] v,
                                                  input int unsigned    n);
    logic [BIN_W-1:0] acc;
    acc = '0;
    for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
      if (i < int'(n)) begin
        acc = (acc * BIN_W'(10)) + BIN_W'(v[i*BCD_W +: BCD_W]);
      end
    end
    return acc;
  endfunction

  // 10**n, used for the all-9s binary value.
  function automatic logic [BIN_W-1:0] pow10(input int unsigned n);
    logic [BIN_W-1:0] p;
    p = BIN_W'(1);
    for (int unsigned i = 0; i < n; i++) begin
      p = p * BIN_W'(10);
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell of the decade counter.
// Ports: clk, rst_n (async active-low), step_in (advance this digit),
// up (direction), clr (sync clear), ld/ld_digit (sync load),
// digit (registered value), is_max/is_zero (decodes of the digit register).
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_in,
  input  logic             up,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_digit,
  output logic [BCD_W-1:0] digit,
  output logic             is_max,
  output logic             is_zero
);

  assign is_max  = (digit == BCD_MAX);
  assign is_zero = (digit == '0);

  // Clear beats load beats step; stepping past 9/0 rolls the digit over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (ld) begin
      digit <= ld_digit;
    end else if (step_in) begin
      if (up) begin
        digit <= is_max ? '0 : digit + BCD_W'(1);
      end else begin
        digit <= is_zero ? BCD_MAX : digit - BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_decade_counter.sv
// Multi-digit BCD up/down counter with sync clear/load, wrap-or-saturate
// terminal handling, sticky ovf/unf flags and an optional binary shadow.
// Ports: clk, rst_n (async active-low), en, up, clr, ld, ld_val, clr_flags;
// outputs count, count_bin, carry, ovf, unf, ld_err (all registered).
// Build option: BCD_CNT_BIN_SHADOW_EN builds the binary shadow register;
// without it count_bin is tied to 0.
module bcd_decade_counter
  import bcd_cnt_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    ld,
  input  logic [BCD_W*DIGITS-1:0] ld_val,
  input  logic                    clr_flags,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic [BIN_W-1:0]        count_bin,
  output logic                    carry,
  output logic                    ovf,
  output logic                    unf,
  output logic                    ld_err
);

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] max_mask;
  logic [DIGITS-1:0] zero_mask;
  logic [DIGITS-1:0] step;
  logic              ld_valid;
  logic              act_ld;
  logic              act_en;
  logic              ld_ok;
  logic              term_up;
  logic              term_dn;
  logic              hold;

  // Every nibble of the load word must be a decimal digit.
  always_comb begin
    ld_valid = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(ld_val[i*BCD_W +: BCD_W])) begin
        ld_valid = 1'b0;
      end
    end
  end

  assign act_ld  = !clr && ld;
  assign act_en  = !clr && !ld && en;
  assign ld_ok   = act_ld && ld_valid;
  assign term_up = act_en && up  && (&is_max);
  assign term_dn = act_en && !up && (&is_zero);
  assign hold    = (term_up || term_dn) && !WRAP;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      // Each digit gets its own flat AND over the digits below it, so the
      // enable depth is one reduction rather than a digit-to-digit ripple.
      localparam logic [DIGITS-1:0] LOWER = {DIGITS{1'b1}} >> (DIGITS - g);

      assign max_mask[g]  = &(is_max  | ~LOWER);
      assign zero_mask[g] = &(is_zero | ~LOWER);
      assign step[g]      = act_en && !hold && (up ? max_mask[g] : zero_mask[g]);

      bcd_digit u_digit (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_in  (step[g]),
        .up       (up),
        .clr      (clr),
        .ld       (ld_ok),
        .ld_digit (ld_val[g*BCD_W +: BCD_W]),
        .digit    (count[g*BCD_W +: BCD_W]),
        .is_max   (is_max[g]),
        .is_zero  (is_zero[g])
      );
    end
  endgenerate

  // Event pulses and sticky flags; a new terminal event beats clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry  <= 1'b0;
      ld_err <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      carry  <= term_up || term_dn;
      ld_err <= act_ld && !ld_valid;
      if (term_up) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end
      if (term_dn) begin
        unf <= 1'b1;
      end else if (clr_flags) begin
        unf <= 1'b0;
      end
    end
  end

`ifdef BCD_CNT_BIN_SHADOW_EN
  localparam logic [BIN_W-1:0] MAX_BIN = pow10(DIGITS) - BIN_W'(1);

  logic [BIN_W-1:0] bin_q;

  // Binary shadow follows the BCD register step for step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
    end else if (clr) begin
      bin_q <= '0;
    end else if (ld_ok) begin
      bin_q <= bcd_to_bin(BIN_W'(ld_val), DIGITS);
    end else if (act_en && !hold) begin
      if (term_up) begin
        bin_q <= '0;
      end else if (term_dn) begin
        bin_q <= MAX_BIN;
      end else if (up) begin
        bin_q <= bin_q + BIN_W'(1);
      end else begin
        bin_q <= bin_q - BIN_W'(1);
      end
    end
  end

  assign count_bin = bin_q;
`else
  assign count_bin = '0;
`endif

endmodule

// File: tb/tb_bcd_decade_counter.sv
module tb_bcd_decade_counter;

  localparam int NDIG = 4;
  localparam int VMAX = 9999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, up, clr, ld, clr_flags;
  logic [15:0] ld_val;

  // Index 0: WRAP=1 instance, index 1: WRAP=0 instance.
  logic [15:0] cnt  [2];
  logic [31:0] cbin [2];
  logic        car  [2];
  logic        ov   [2];
  logic        un   [2];
  logic        lerr [2];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_v     [2];
  bit m_ovf   [2];
  bit m_unf   [2];
  bit m_carry [2];
  bit m_lderr [2];

  always #5 clk = ~clk;

  bcd_decade_counter #(.DIGITS(NDIG), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .clr_flags(clr_flags), .count(cnt[0]), .count_bin(cbin[0]),
    .carry(car[0]), .ovf(ov[0]), .unf(un[0]), .ld_err(lerr[0])
  );

  bcd_decade_counter #(.DIGITS(NDIG), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .clr_flags(clr_flags), .count(cnt[1]), .count_bin(cbin[1]),
    .carry(car[1]), .ovf(ov[1]), .unf(un[1]), .ld_err(lerr[1])
  );

  // Decimal integer to packed BCD by repeated division.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] b);
    logic [15:0] w;
    w = b;
    for (int i = 0; i < NDIG; i++) if (w[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    logic [15:0] w;
    int r;
    w = b;
    r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(w[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] exp_bin(input int v);
`ifdef BCD_CNT_BIN_SHADOW_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v * 0);
`endif
  endfunction

  task automatic drive(input bit c, input bit l, input logic [15:0] lv,
                       input bit e, input bit u, input bit cf);
    clr = c; ld = l; ld_val = lv; en = e; up = u; clr_flags = cf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances the reference by one clock using the currently driven inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit wrap, tu, td;
      wrap = (k == 0);
      tu = 1'b0; td = 1'b0;
      m_lderr[k] = 1'b0;
      if (clr) begin
        m_v[k] = 0;
      end else if (ld) begin
        if (bcd_ok(ld_val)) m_v[k] = from_bcd(ld_val);
        else m_lderr[k] = 1'b1;
      end else if (en) begin
        if (up) begin
          if (m_v[k] == VMAX) begin tu = 1'b1; m_v[k] = wrap ? 0 : VMAX; end
          else m_v[k] = m_v[k] + 1;
        end else begin
          if (m_v[k] == 0) begin td = 1'b1; m_v[k] = wrap ? VMAX : 0; end
          else m_v[k] = m_v[k] - 1;
        end
      end
      m_carry[k] = tu | td;
      if (tu) m_ovf[k] = 1'b1; else if (clr_flags) m_ovf[k] = 1'b0;
      if (td) m_unf[k] = 1'b1; else if (clr_flags) m_unf[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 16'h0, 0, 1, 0);
    #12;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cnt[k], cbin[k], car[k], ov[k], un[k], lerr[k]} !== 52'd0) begin
        errors++;
        $display("FAIL reset[%0d]: count=%h bin=%0d carry=%b ovf=%b unf=%b ld_err=%b, required all 0",
                 k, cnt[k], cbin[k], car[k], ov[k], un[k], lerr[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up_wrap();
    logic [15:0] ec [3];
    logic [31:0] eb [3];
    logic        ecar [3];
    ec[0] = 16'h9999; ec[1] = 16'h0000; ec[2] = 16'h0001;
    eb[0] = exp_bin(9999); eb[1] = exp_bin(0); eb[2] = exp_bin(1);
    ecar[0] = 1'b0; ecar[1] = 1'b1; ecar[2] = 1'b0;
    drive(0, 1, 16'h9998, 0, 1, 0);
    tick();
    drive(0, 0, 16'h0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cnt[0] !== ec[i] || cbin[0] !== eb[i] || car[0] !== ecar[i]) begin
        errors++;
        $display("FAIL up_wrap step%0d: count=%h bin=%0d carry=%b, required count=%h bin=%0d carry=%b",
                 i, cnt[0], cbin[0], car[0], ec[i], eb[i], ecar[i]);
      end
    end
    checks++;
    if (ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_ovf: ovf=%b, required 1", ov[0]);
    end
    checks++;
    if (cnt[1] !== 16'h9999 || ov[1] !== 1'b1) begin
      errors++;
      $display("FAIL up_sat_hold: count=%h ovf=%b, required 9999 1", cnt[1], ov[1]);
    end
  endtask

  task automatic test_down_sat();
    drive(1, 0, 16'h0, 0, 1, 1);
    tick();
    drive(0, 0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (cnt[1] !== 16'h0000 || car[1] !== 1'b1 || un[1] !== 1'b1 || ov[1] !== 1'b0) begin
        errors++;
        $display("FAIL down_sat step%0d: count=%h carry=%b unf=%b ovf=%b, required 0000 1 1 0",
                 i, cnt[1], car[1], un[1], ov[1]);
      end
    end
    checks++;
    if (cnt[0] !== 16'h9998 || cbin[0] !== exp_bin(9998)) begin
      errors++;
      $display("FAIL down_wrap: count=%h bin=%0d, required 9998 %0d", cnt[0], cbin[0], exp_bin(9998));
    end
  endtask

  task automatic test_invalid_load();
    drive(1, 0, 16'h0, 0, 1, 0);
    tick();
    drive(0, 1, 16'h12A4, 0, 1, 0);
    tick();
    checks++;
    if (cnt[0] !== 16'h0000 || lerr[0] !== 1'b1) begin
      errors++;
      $display("FAIL bad_load: count=%h ld_err=%b, required 0000 1", cnt[0], lerr[0]);
    end
    drive(0, 0, 16'h0, 0, 1, 0);
    tick();
    checks++;
    if (lerr[0] !== 1'b0) begin
      errors++;
      $display("FAIL ld_err_pulse: ld_err=%b, required 0", lerr[0]);
    end
    drive(0, 1, 16'h0459, 0, 1, 0);
    tick();
    checks++;
    if (cnt[0] !== 16'h0459 || cbin[0] !== exp_bin(459) || lerr[0] !== 1'b0) begin
      errors++;
      $display("FAIL good_load: count=%h bin=%0d ld_err=%b, required 0459 %0d 0",
               cnt[0], cbin[0], lerr[0], exp_bin(459));
    end
  endtask

  task automatic test_priority();
    drive(0, 1, 16'h0009, 0, 1, 0);
    tick();
    drive(1, 1, 16'h0500, 1, 1, 0);
    tick();
    checks++;
    if (cnt[0] !== 16'h0000) begin
      errors++;
      $display("FAIL prio_clr: count=%h, required 0000", cnt[0]);
    end
    drive(0, 1, 16'h0500, 1, 1, 0);
    tick();
    checks++;
    if (cnt[0] !== 16'h0500 || cbin[0] !== exp_bin(500)) begin
      errors++;
      $display("FAIL prio_ld: count=%h bin=%0d, required 0500 %0d", cnt[0], cbin[0], exp_bin(500));
    end
  endtask

  task automatic test_flag_race();
    drive(0, 1, 16'h9999, 0, 1, 1);
    tick();
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL flag_preclear: ovf=%b, required 0", ov[0]);
    end
    drive(0, 0, 16'h0, 1, 1, 1);
    tick();
    checks++;
    if (ov[0] !== 1'b1 || car[0] !== 1'b1) begin
      errors++;
      $display("FAIL flag_race_set: ovf=%b carry=%b, required 1 1", ov[0], car[0]);
    end
    drive(0, 0, 16'h0, 0, 1, 1);
    tick();
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear: ovf=%b, required 0", ov[0]);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 16'h0135, 0, 1, 0);
    tick();
    drive(0, 0, 16'h0, 1, 1, 0);
    tick();
    tick();
    checks++;
    if (cnt[0] !== 16'h0137) begin
      errors++;
      $display("FAIL pre_reset: count=%h, required 0137", cnt[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cnt[k], cbin[k], car[k], ov[k], un[k], lerr[k]} !== 52'd0) begin
        errors++;
        $display("FAIL async_reset[%0d]: count=%h bin=%0d carry=%b ovf=%b unf=%b ld_err=%b, required all 0",
                 k, cnt[k], cbin[k], car[k], ov[k], un[k], lerr[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (cnt[0] !== 16'h0002 || cbin[0] !== exp_bin(2)) begin
      errors++;
      $display("FAIL post_reset: count=%h bin=%0d, required 0002 %0d", cnt[0], cbin[0], exp_bin(2));
    end
  endtask

  task automatic test_random();
    logic [15:0] lv;
    for (int k = 0; k < 2; k++) begin
      m_v[k] = from_bcd(cnt[k]);
      m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
    end
    // Anchor the model to a known state before random traffic.
    drive(0, 1, 16'h0002, 0, 1, 1);
    tick();
    model_step();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       lv = 16'($urandom);
        1:       lv = to_bcd(($urandom_range(0, 1) == 0) ? VMAX - int'($urandom_range(0, 2))
                                                          : int'($urandom_range(0, 2)));
        default: lv = to_bcd(int'($urandom_range(0, VMAX)));
      endcase
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, lv,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0);
      tick();
      model_step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (cnt[k] !== to_bcd(m_v[k]) || cbin[k] !== exp_bin(m_v[k]) ||
            car[k] !== m_carry[k] || ov[k] !== m_ovf[k] || un[k] !== m_unf[k] ||
            lerr[k] !== m_lderr[k]) begin
          errors++;
          $display("FAIL random[%0d] cyc%0d: count=%h bin=%0d c=%b o=%b u=%b le=%b, required %h %0d %b %b %b %b",
                   k, n, cnt[k], cbin[k], car[k], ov[k], un[k], lerr[k],
                   to_bcd(m_v[k]), exp_bin(m_v[k]), m_carry[k], m_ovf[k], m_unf[k], m_lderr[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_invalid_load();
    test_priority();
    test_flag_race();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_decade_counter.md
# bcd_decade_counter

Parametrised multi-digit BCD decade counter with up/down direction, synchronous load and clear, a ripple-free per-digit carry chain, a wrap-or-saturate terminal mode and sticky overflow/underflow status. It generalises the single 32-bit decimal counter with overflow flag into the counter resource used by the display and timing front-ends. Outputs are fully registered.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `WRAP`, default 1: terminal behaviour. 1 means wrap around; 0 means saturate at the terminal value.
- `CLK`, input, 1: single clock, rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: count enable for one step per cycle.
- `up`, input, 1: direction. 1 counts up; 0 counts down.
- `clr`, input, 1: synchronous clear to 0.
- `ld`, input, 1: synchronous load of `ld_val`.
- `ld_val`, input, 4*DIGITS: BCD value to load.
- `clr_flags`, input, 1: clears the sticky `ovf` and `unf` flags.
- `count`, output, 4*DIGITS: current BCD value; digit 0 occupies bits [3:0].
- `count_bin`, output, 32: binary equivalent of `count`.
- `carry`, output, 1: one-cycle pulse on a terminal event (wrap or saturation hit).
- `ovf`, output, 1: sticky flag set when an up-count passes all-9s.
- `unf`, output, 1: sticky flag set when a down-count passes 0.
- `ld_err`, output, 1: one-cycle pulse when a load is rejected.

## Operation
- Reset: `count`=0, `count_bin`=0, `carry`=0, `ovf`=0, `unf`=0, `ld_err`=0.
- Per-cycle priority: `clr` > `ld` > `en`. Only the highest-priority asserted action takes effect.
- Clear: `count`=0 and `count_bin`=0. Flags are not touched.
- Load:
  - If every nibble of `ld_val` is ≤9, `count`=`ld_val` and `count_bin` is set to its binary value.
  - Otherwise `count` is unchanged and `ld_err` pulses.
- Count up:
  - Digit i increments when all lower digits equal 9.
  - A digit at 9 that increments becomes 0 and generates a carry.
- Count down:
  - Digit i decrements when all lower digits equal 0.
  - A digit at 0 that decrements becomes 9 and generates a borrow.
- Terminal event, up at all-9s:
  - `WRAP`=1: count becomes 0.
  - `WRAP`=0: count holds at all-9s.
  - In both cases `carry` pulses and `ovf` is set.
- Terminal event, down at 0:
  - `WRAP`=1: count becomes all-9s.
  - `WRAP`=0: count holds at 0.
  - In both cases `carry` pulses and `unf` is set.
- With `WRAP`=0 the flags and `carry` re-assert on every enabled cycle spent at the terminal value.
- Flag update: if `clr_flags` coincides with a new terminal event, set wins.
- `count_bin` update: tracks `count` by ±1, 0, or the loaded value. For DIGITS=8 the value fits in 27 bits; the upper bits are 0.

## Timing
- All outputs change one cycle after the qualifying inputs are sampled on `CLK`. There is no combinational path from input to output.
- Sustained `en` yields exactly one step per cycle.
- `carry` and `ld_err` are high for exactly one cycle per event.
- Changing `up` between cycles takes effect on the next step; there is no turnaround cycle.
- Asserting `RST_N` low mid-count forces all outputs to their reset values immediately (asynchronously). Counting resumes on the first enabled edge after deassertion.
- Critical path is the all-9s/all-0s detect across DIGITS. It must close at DIGITS=8 using a precomputed per-digit terminal mask, not a serial ripple.

## Configuration
- `BCD_CNT_BIN_SHADOW_EN` defined: the binary shadow register and its update logic are built, and `count_bin` behaves as described above.
- Not defined: the shadow register is removed and `count_bin` is tied to 0. The port list does not change.

## Structure
- Package `bcd_cnt_pkg` contains:
  - `BCD_W`=4
  - `BCD_MAX`=4'd9
  - `BIN_W`=32
  - function `bcd_digit_valid`
  - function `bcd_to_bin`, used on load
- Sub-module `bcd_digit`: one 4-bit digit cell.
  - Inputs: `step_in`, `up`, `clr`, `ld`, `ld_digit`.
  - Outputs: `digit`, `is_max`, `is_zero`.
  - Instantiated DIGITS times in a generate loop.
- The top level owns the terminal masks, flags, `carry`, `ld_err` and the shadow register.

## Test plan
All scenarios use DIGITS=4.
- Up-count with wrap: `WRAP`=1, load 9998, `en`=1 `up`=1 for 3 cycles → `count` 9999, 0000, 0001. `carry` is high only in the 0000 cycle; `ovf`=1; `count_bin` 9999, 0, 1.
- Down-count with saturate: `WRAP`=0, clear, then `en`=1 `up`=0 for 2 cycles → `count` stays 0000; `carry` high both cycles; `unf`=1; `ovf`=0.
- Invalid load: load 0x12A4 → `count` unchanged and `ld_err` pulses for one cycle. Then load 0x0459 → `count`=0459 and `count_bin`=459.
- Priority: with `count`=0009, assert `clr`, `ld`(0x0500) and `en` together → `count`=0000. Next cycle assert `ld` and `en` together → `count`=0500.
- Flag race: hold `clr_flags` while stepping up from 9999 → `ovf`=1. With `clr_flags` alone on the following cycle → `ovf`=0.
- Asynchronous reset: pull `RST_N` low mid-cycle during counting at 0137 → all outputs are 0 before the next `CLK` edge. Release, then 2 enabled cycles → `count`=0002.
